// File: rtl/booth_recode_stream.sv
// ============================================================================
// Module   : booth_recode_stream
// Purpose  : Sequential radix-2^K Booth recoder; streams digits LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_recode_stream #(
  parameter  int WIDTH  = 16,
  parameter  int K      = 3,
  parameter  int SIGNED = 1,
  localparam int NDIG   = (SIGNED != 0) ? (WIDTH + K - 1) / K : (WIDTH + K) / K,
  localparam int EXTW   = NDIG * K + 1,
  localparam int IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic             in_skip_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K:0]       out_digit,
  output logic             out_neg,
  output logic [K-1:0]     out_mag,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // d = -2^(K-1)*g[K] + g[K-1:1] + g[0], kept in K+1 bit two's complement
  function automatic logic [K:0] f_digit(input logic [K:0] g);
    logic [K:0] pos;
    logic [K:0] neg;
    pos = {2'b00, g[K-1:1]} + {{K{1'b0}}, g[0]};
    neg = {1'b0, g[K], {(K-1){1'b0}}};
    return pos - neg;
  endfunction

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [EXTW-1:0] r_x;
  logic [NDIG-1:0] r_mask;
  logic            r_skip;
  logic [IDXW-1:0] r_idx;

  logic [EXTW-1:0] w_xload;
  logic [K:0]      w_ld_dig  [NDIG];
  logic [K:0]      w_cur_dig [NDIG];
  logic [NDIG-1:0] w_ld_mask;
  logic [IDXW-1:0] w_first_idx;
  logic [IDXW-1:0] w_next_set;
  logic            w_has_higher;
  logic [IDXW-1:0] w_next_idx;
  logic            w_last;
  logic [K:0]      w_digit;
  logic [K:0]      w_digit_neg;
  logic            w_load;
  logic            w_hs;

  if (SIGNED != 0) begin : g_sext
    assign w_xload = EXTW'($signed({in_operand, 1'b0}));
  end else begin : g_zext
    assign w_xload = EXTW'({in_operand, 1'b0});
  end

  // Every group is recoded twice: once from the incoming operand for the
  // nonzero mask, once from the held operand for the presented digit.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_grp
    assign w_ld_dig[gi]  = f_digit(w_xload[K*gi +: K+1]);
    assign w_ld_mask[gi] = |w_ld_dig[gi];
    assign w_cur_dig[gi] = f_digit(r_x[K*gi +: K+1]);
  end

  always_comb begin
    w_first_idx = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (w_ld_mask[i]) w_first_idx = IDXW'(i);
    end
  end

  always_comb begin
    w_next_set   = '0;
    w_has_higher = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (r_mask[i] && (IDXW'(i) > r_idx)) begin
        w_next_set   = IDXW'(i);
        w_has_higher = 1'b1;
      end
    end
  end

  assign w_last      = r_skip ? !w_has_higher : (r_idx == IDXW'(NDIG - 1));
  assign w_next_idx  = r_skip ? w_next_set : (r_idx + IDXW'(1));
  assign w_digit     = w_cur_dig[r_idx];
  assign w_digit_neg = ~w_digit + {{K{1'b0}}, 1'b1};
  assign w_load      = in_valid && in_ready;
  assign w_hs        = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_state_nxt = S_RUN;
      S_RUN:  if (w_hs && w_last) w_state_nxt = w_load ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A last-digit handshake frees the operand register in the same cycle,
  // so a waiting operand is accepted without a bubble.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_digit = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_neg   = 1'b0;
    out_mag   = '0;
    if (r_state == S_RUN) begin
      in_ready  = out_ready && w_last;
      out_valid = 1'b1;
      out_digit = w_digit;
      out_idx   = r_idx;
      out_last  = w_last;
      out_neg   = w_digit[K];
      out_mag   = w_digit[K] ? w_digit_neg[K-1:0] : w_digit[K-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_mask <= '0;
      r_skip <= 1'b0;
      r_idx  <= '0;
    end else if (w_load) begin
      r_x    <= w_xload;
      r_mask <= w_ld_mask;
      r_skip <= in_skip_zero;
      r_idx  <= in_skip_zero ? w_first_idx : '0;
    end else if (w_hs) begin
      r_idx  <= w_next_idx;
    end
  end

endmodule

`default_nettype wire
